// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings and the opcode legality check.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SUB = 3'b100;
  localparam logic [OPW-1:0] OP_MUL = 3'b101;
  localparam logic [OPW-1:0] OP_SLT = 3'b110;

  // 011 and 111 are unassigned and must be answered with an error response
  function automatic logic op_is_legal(input logic [OPW-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_SLT: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared between requesters; unassigned opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Opcode decode; ADD/SUB/MUL wrap modulo 2^WIDTH by truncation
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter for one shared ALU: grants at most one op per cycle and
// returns a registered response to the winning port on the following cycle.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prio_mode,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp0_zero,
  output logic             resp0_err,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_data,
  output logic             resp1_zero,
  output logic             resp1_err
);

  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             legal;
  logic [WIDTH-1:0] next_data;
  logic             next_zero;
  logic             next_err;
  logic             resp0_pulse;
  logic             resp1_pulse;

  // Grant: port 0 wins unless port 1 is owed the round-robin turn
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      grant0 = req0_valid && (!req1_valid || prio_mode || last_grant);
      grant1 = req1_valid && !grant0;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux parks on port 0 when nobody is granted
  always_comb begin
    alu_op = req0_op;
    alu_a  = req0_a;
    alu_b  = req0_b;
    if (grant1) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end else begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end
  end

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  // Illegal opcodes report err with data and zero forced low
  always_comb begin
    legal     = op_is_legal(alu_op);
    next_data = '0;
    next_zero = 1'b0;
    next_err  = 1'b1;
    if (legal) begin
      next_data = alu_result;
      next_zero = (alu_result == '0);
      next_err  = 1'b0;
    end else begin
      next_data = '0;
      next_zero = 1'b0;
      next_err  = 1'b1;
    end
  end

  // Response registers and round-robin pointer; fields hold between pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      resp0_pulse <= 1'b0;
      resp1_pulse <= 1'b0;
      resp0_data  <= '0;
      resp0_zero  <= 1'b0;
      resp0_err   <= 1'b0;
      resp1_data  <= '0;
      resp1_zero  <= 1'b0;
      resp1_err   <= 1'b0;
    end else begin
      resp0_pulse <= grant0;
      resp1_pulse <= grant1;
      if (grant0) begin
        resp0_data <= next_data;
        resp0_zero <= next_zero;
        resp0_err  <= next_err;
        last_grant <= 1'b0;
      end
      if (grant1) begin
        resp1_data <= next_data;
        resp1_zero <= next_zero;
        resp1_err  <= next_err;
        last_grant <= 1'b1;
      end
    end
  end

  // A response still in flight when reset arrives is never presented
  assign resp0_valid = resp0_pulse & rst_n;
  assign resp1_valid = resp1_pulse & rst_n;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes expected responses into
// per-port queues, a monitor on the falling edge pops and compares them.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prio_mode = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]  req0_op = 3'b000, req1_op = 3'b000;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_zero, resp1_zero, resp0_err, resp1_err;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .resp1_zero(resp1_zero), .resp1_err(resp1_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic ok, input string got, input string exp);
    n_total++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got %s, required %s", name, got, exp);
  endtask

  // Monitor: every presented response must match the head of its port queue
  always @(negedge clk) begin
    exp_t r;
    cyc = cyc + 1;
    if (resp0_valid === 1'b1) begin
      if (q0.size() == 0) chk("resp0_unexpected", 1'b0, "valid=1", "valid=0");
      else begin
        r = q0.pop_front();
        chk("resp0", (resp0_data === r.d) && (resp0_zero === r.z) &&
                     (resp0_err === r.e) && (cyc == r.cyc),
            $sformatf("d=%h z=%b e=%b cyc=%0d", resp0_data, resp0_zero, resp0_err, cyc),
            $sformatf("d=%h z=%b e=%b cyc=%0d", r.d, r.z, r.e, r.cyc));
      end
    end
    if (resp1_valid === 1'b1) begin
      if (q1.size() == 0) chk("resp1_unexpected", 1'b0, "valid=1", "valid=0");
      else begin
        r = q1.pop_front();
        chk("resp1", (resp1_data === r.d) && (resp1_zero === r.z) &&
                     (resp1_err === r.e) && (cyc == r.cyc),
            $sformatf("d=%h z=%b e=%b cyc=%0d", resp1_data, resp1_zero, resp1_err, cyc),
            $sformatf("d=%h z=%b e=%b cyc=%0d", r.d, r.z, r.e, r.cyc));
      end
    end
  end

  // Called at posedge+2: drive, check grants, queue expectation, advance one edge
  task automatic step(input logic pm,
                      input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] gexp, input logic [31:0] d, input logic z, input logic e);
    exp_t r;
    prio_mode = pm;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    chk("grant", {req1_ready, req0_ready} === gexp,
        $sformatf("%b", {req1_ready, req0_ready}), $sformatf("%b", gexp));
    r.d = d; r.z = z; r.e = e; r.cyc = cyc + 2;
    if (gexp[0]) q0.push_back(r);
    if (gexp[1]) q1.push_back(r);
    @(posedge clk);
    #2;
  endtask

  initial begin
    @(posedge clk);
    #2;
    // Reset held with both ports requesting
    step(1'b0, 1'b1, 3'b010, 32'd5, 32'd7, 1'b1, 3'b100, 32'd3, 32'd10, 2'b00, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b010, 32'd5, 32'd7, 1'b1, 3'b100, 32'd3, 32'd10, 2'b00, 32'd0, 1'b0, 1'b0);
    chk("reset_resp0", {resp0_valid, resp0_data, resp0_zero, resp0_err} === 35'd0,
        $sformatf("%h", {resp0_valid, resp0_data, resp0_zero, resp0_err}), "0");
    chk("reset_resp1", {resp1_valid, resp1_data, resp1_zero, resp1_err} === 35'd0,
        $sformatf("%h", {resp1_valid, resp1_data, resp1_zero, resp1_err}), "0");
    rst_n = 1'b1;

    // Round-robin contention: ADD 5+7 vs SUB 3-10
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        step(1'b0, 1'b1, 3'b010, 32'd5, 32'd7, 1'b1, 3'b100, 32'd3, 32'd10, 2'b01, 32'd12, 1'b0, 1'b0);
      else
        step(1'b0, 1'b1, 3'b010, 32'd5, 32'd7, 1'b1, 3'b100, 32'd3, 32'd10, 2'b10, 32'hFFFF_FFF9, 1'b0, 1'b0);
    end

    // Fixed priority, then port 0 drops out
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 3'b010, 32'd5, 32'd7, 1'b1, 3'b100, 32'd3, 32'd10, 2'b01, 32'd12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'b010, 32'd5, 32'd7, 1'b1, 3'b100, 32'd3, 32'd10, 2'b10, 32'hFFFF_FFF9, 1'b0, 1'b0);

    // Arithmetic edge cases
    step(1'b0, 1'b1, 3'b101, 32'h0001_0000, 32'h0001_0000, 1'b0, 3'b000, 32'd0, 32'd0, 2'b01, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b100, 32'd4, 32'd4, 1'b0, 3'b000, 32'd0, 32'd0, 2'b01, 32'd0, 1'b1, 1'b0);

    // Illegal opcodes on port 1; pointer must advance past port 1 each time
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 3'b011, 32'd9, 32'd9, 2'b10, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'b001, 32'hF0, 32'h0F, 1'b1, 3'b111, 32'd9, 32'd9, 2'b01, 32'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b001, 32'hF0, 32'h0F, 1'b1, 3'b111, 32'd9, 32'd9, 2'b10, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0);
    chk("hold_fields", {resp1_valid, resp1_err, resp1_data, resp0_data} === {1'b0, 1'b1, 32'd0, 32'hFF},
        $sformatf("v1=%b e1=%b d1=%h d0=%h", resp1_valid, resp1_err, resp1_data, resp0_data),
        "v1=0 e1=1 d1=00000000 d0=000000ff");

    // Reset right after an accepted AND: its response must never appear
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'hFF00; req0_b = 32'h0FF0;
    #1;
    chk("midreset_accept", req0_ready === 1'b1, $sformatf("%b", req0_ready), "1");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("midreset_valid", resp0_valid === 1'b0, $sformatf("%b", resp0_valid), "0");
    @(posedge clk);
    #2;
    chk("midreset_cleared", {resp0_valid, resp0_data, resp1_err} === 34'd0,
        $sformatf("%h", {resp0_valid, resp0_data, resp1_err}), "0");
    rst_n = 1'b1;
    step(1'b0, 1'b1, 3'b010, 32'd1, 32'd1, 1'b1, 3'b010, 32'd2, 32'd2, 2'b01, 32'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0);

    chk("drain_q0", q0.size() == 0, $sformatf("%0d left", q0.size()), "0 left");
    chk("drain_q1", q1.size() == 0, $sformatf("%0d left", q1.size()), "0 left");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one shared `alu` instance between two requesters: port 0 is the main execute path and port 1 is the address/branch-compare path. Each cycle it grants at most one operation, drives the ALU, and registers the result back to the winning port one cycle later. It also rejects the two unused opcodes with an error response.

## Interface
Parameters
- `WIDTH`, 32, operand and result width.
- `OPW`, 3, opcode width.

Ports
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `prio_mode`  in  1  0 selects round-robin; 1 selects fixed priority with port 0 winning.
- `req0_valid`, `req1_valid`  in  1  request present on the port.
- `req0_op`, `req1_op`  in  OPW  ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_ready`, `req1_ready`  out  1  grant, combinational in the same cycle.
- `resp0_valid`, `resp1_valid`  out  1  one-cycle pulse carrying the result.
- `resp0_data`, `resp1_data`  out  WIDTH  registered result.
- `resp0_zero`, `resp1_zero`  out  1  registered result==0.
- `resp0_err`, `resp1_err`  out  1  registered illegal-opcode flag.

## Operation
- **Handshake.** An operation is accepted when `reqN_valid && reqN_ready`.
  - A requester must hold valid, op, a and b stable until ready.
  - Ready is never asserted to a port whose valid is low.
  - At most one ready is high per cycle.
- **Arbitration.**
  - Only one port valid: that port is granted.
  - Both valid, `prio_mode`=1: port 0 is granted.
  - Both valid, `prio_mode`=0: the port not granted most recently wins.
  - State: `last_grant` (1 bit). It updates only on an accepted operation, in either mode.
- **ALU ops.** The shared ALU is driven from the granted port's op/a/b. With no grant, the mux is held on port 0.
  - 000 AND
  - 001 OR
  - 010 ADD, modulo 2^WIDTH
  - 100 SUB, modulo 2^WIDTH
  - 101 MUL, low WIDTH bits of the product
  - 110 SLT: result 1 if signed A < signed B, else 0
- **Illegal opcodes (011, 111).** The operation is accepted and consumes the grant. The response carries err=1, data=0, zero=0.
- **Response.**
  - The cycle after acceptance, the owning port's `respN_valid` is 1 and the other port's is 0.
  - data, zero and err are registered from that cycle's ALU/decode.
  - The data, zero and err fields hold their last value when valid is 0.
  - There is no response backpressure; the requester must sample the response during the valid pulse.
- **Back-to-back.** A new grant may occur in the same cycle a previous response is being presented, giving full throughput of 1 op/cycle.

## Timing
- **Latency.** Accept at edge N produces the response on cycle N+1.
- **Reset (`rst_n`=0 sampled at an edge).** Outputs after that edge:
  - `respN_valid`, `respN_data`, `respN_zero`, `respN_err` = 0.
  - `last_grant` = 1, so port 0 wins the first contention.
  - Ready outputs are forced to 0 while `rst_n`=0, so no accept occurs during reset.
- **Reset mid-operation.** An operation accepted on the cycle before reset has its response discarded; valid stays 0.
- **Mode switch.** `prio_mode` is sampled combinationally every cycle. Switching it does not reset `last_grant`.
- **Simultaneous events.** A request arriving on the loser port is retried automatically because it stays valid. Under round-robin, a continuously contended port waits at most one cycle.

## Structure
- A shared package `alu_pkg` holds:
  - the opcode localparams (`OP_AND`=000, `OP_OR`=001, `OP_ADD`=010, `OP_SUB`=100, `OP_MUL`=101, `OP_SLT`=110);
  - an `op_is_legal` function;
  - `WIDTH`.
- Sub-module: the existing `alu`, instantiated once. The grant mux, `last_grant`, and the response registers live in `alu_share_arbiter`. No other sub-module.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 cycles with both ports valid. Required: both readys 0; all resp outputs 0; after release, the first contention grants port 0.
- **Round-robin contention.** Both ports valid for 4 cycles: port 0 ADD 5+7, port 1 SUB 3−10. Required grants 0,1,0,1. Responses are 12 (zero=0) on port 0 and 0xFFFFFFF9 on port 1, each one cycle after its grant.
- **Fixed priority.** `prio_mode`=1 with both valid for 3 cycles. Required: port 0 granted every cycle and port 1 ready stays 0; after port 0 drops valid, port 1 is granted the next cycle.
- **Arithmetic edges.**
  - MUL 0x10000×0x10000 gives 0, zero=1.
  - SLT 0xFFFFFFFF vs 1 gives 1 (signed).
  - SUB 4−4 gives 0, zero=1.
- **Illegal opcodes.** Port 1 op 011, then op 111. Required: each accepted, with resp1_err=1, data=0, zero=0; round-robin pointer advances.
- **Reset mid-operation.** Accept a port 0 AND, then assert `rst_n`=0 at the next edge. Required: `resp0_valid` never pulses for that operation.
